// File: rtl/gpr_file_sb_pkg.sv
// gpr_pkg: shared sizing defaults and types for the GPR file and its scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpr_pkg;

  localparam int GPR_DATA_W   = 16;
  localparam int GPR_NUM_REGS = 8;
  localparam int GPR_ADDR_W   = $clog2(GPR_NUM_REGS);

  typedef logic [GPR_ADDR_W-1:0] gpr_idx_t;
  typedef logic [GPR_DATA_W-1:0] gpr_word_t;

  // Index of the hard-wired zero register.
  localparam int GPR_ZERO = 0;

endpackage

// File: rtl/gpr_file_sb_scoreboard.sv
// gpr_scoreboard: per-register busy bits, reservation acknowledge and busy counter.
// Latency: rsv_ack combinational; busy/busy_cnt update on the clk edge after an accepted reserve or write.
// Backpressure: rsv_ack low with rsv_en high is a stall; the requester holds, nothing is queued.
// Ports: clk, rst_n (async active-low); wr_en/wr_addr (writeback clears busy);
//        rsv_en/rsv_addr (issue sets busy); busy (vector), rsv_ack, busy_cnt (registered).
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NUM_REGS = GPR_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                rsv_ack,
  output logic [ADDR_W:0]     busy_cnt
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [ADDR_W:0]     cnt_q;
  logic                rsv_zero;
  logic                wr_zero;
  logic                clr_same;
  logic                set_en;
  logic                clr_en;
  logic                inc;
  logic                dec;

  assign rsv_zero = (rsv_addr == ADDR_W'(GPR_ZERO));
  assign wr_zero  = (wr_addr  == ADDR_W'(GPR_ZERO));

  // A write landing on the requested register this edge frees it for the new producer.
  assign clr_same = wr_en & (wr_addr == rsv_addr);
  assign rsv_ack  = rsv_en & rst_n & (rsv_zero | ~busy_q[rsv_addr] | clr_same);

  assign set_en = rsv_ack & ~rsv_zero;
  assign clr_en = wr_en & ~wr_zero;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[rsv_addr] = 1'b1;
    if (clr_en) clr_vec[wr_addr]  = 1'b1;
  end

  // Count only real bit transitions. Same-index write+reserve on a busy register keeps the
  // bit set (set wins over clear), so it must not decrement.
  assign inc = set_en & ~busy_q[rsv_addr];
  assign dec = clr_en & busy_q[wr_addr] & ~(set_en & (rsv_addr == wr_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= ((busy_q & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
      if (inc && !dec)      cnt_q <= cnt_q + (ADDR_W+1)'(1);
      else if (dec && !inc) cnt_q <= cnt_q - (ADDR_W+1)'(1);
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/gpr_file_sb.sv
// gpr_file_sb: general-purpose register file with busy scoreboard (r0 reads as zero).
// Latency: reads combinational; writes land on the next clk edge (same-cycle forwarding with GPR_BYPASS_EN).
// Backpressure: reservations stall via rsv_ack=0 while the target is busy; writes are always accepted.
// Ports: clk, rst_n (async active-low); rd_addr1/2 -> rd_data1/2, rd_busy1/2;
//        wr_en/wr_addr/wr_data (writeback); rsv_en/rsv_addr -> rsv_ack (issue); busy_cnt.
// Config macro: GPR_BYPASS_EN enables write-to-read forwarding.
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = GPR_NUM_REGS,
  // derived; do not override
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ack,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                hit1;
  logic                hit2;
  logic                rd_zero1;
  logic                rd_zero2;

  gpr_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .rsv_ack  (rsv_ack),
    .busy_cnt (busy_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en && wr_addr != ADDR_W'(GPR_ZERO)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_zero1 = (rd_addr1 == ADDR_W'(GPR_ZERO));
  assign rd_zero2 = (rd_addr2 == ADDR_W'(GPR_ZERO));

`ifdef GPR_BYPASS_EN
  assign hit1 = wr_en & (wr_addr == rd_addr1) & ~rd_zero1;
  assign hit2 = wr_en & (wr_addr == rd_addr2) & ~rd_zero2;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // Gate with rst_n so a forwarded write cannot leak out while reset is asserted.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    rd_busy1 = 1'b0;
    rd_busy2 = 1'b0;
    if (rst_n) begin
      if (!rd_zero1) rd_data1 = hit1 ? wr_data : mem[rd_addr1];
      if (!rd_zero2) rd_data2 = hit2 ? wr_data : mem[rd_addr2];
      rd_busy1 = busy[rd_addr1] & ~hit1;
      rd_busy2 = busy[rd_addr2] & ~hit2;
    end
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: directed self-checking bench for gpr_file_sb (default 16x8 configuration).
// Latency: inputs driven 1 time unit after posedge; outputs sampled before the next edge.
// Backpressure: n/a.
module tb_gpr_file_sb;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rd_addr1 = '0;
  logic [DW-1:0] rd_data1;
  logic          rd_busy1;
  logic [AW-1:0] rd_addr2 = '0;
  logic [DW-1:0] rd_data2;
  logic          rd_busy2;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic          rsv_ack;
  logic [AW:0]   busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  gpr_file_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1),
    .rd_busy1 (rd_busy1),
    .rd_addr2 (rd_addr2),
    .rd_data2 (rd_data2),
    .rd_busy2 (rd_busy2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ack  (rsv_ack),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  initial begin
    // 1. reset state, all indices on both ports
    #12;
    for (int i = 0; i < 8; i++) begin
      rd_addr1 = AW'(i);
      rd_addr2 = AW'(7 - i);
      #1;
      chk($sformatf("rst_data1_r%0d", i), 32'(rd_data1), 32'h0);
      chk($sformatf("rst_busy1_r%0d", i), 32'(rd_busy1), 32'h0);
      chk($sformatf("rst_data2_r%0d", 7 - i), 32'(rd_data2), 32'h0);
      chk($sformatf("rst_busy2_r%0d", 7 - i), 32'(rd_busy2), 32'h0);
    end
    chk("rst_cnt", 32'(busy_cnt), 32'h0);
    rsv_en = 1'b1; rsv_addr = 3'd1; #1;
    chk("rst_ack_gated", 32'(rsv_ack), 32'h0);
    rsv_en = 1'b0;
    rst_n = 1'b1;
    tick();

    // 2. write r3, read back; write to r0 ignored
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    tick(); idle();
    rd_addr1 = 3'd3; #1;
    chk("r3_data", 32'(rd_data1), 32'hBEEF);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1234;
    tick(); idle();
    rd_addr2 = 3'd0; #1;
    chk("r0_zero", 32'(rd_data2), 32'h0);
    chk("r0_busy", 32'(rd_busy2), 32'h0);

    // 3. reserve r5, stall on second reserve, writeback clears
    rsv_en = 1'b1; rsv_addr = 3'd5; #1;
    chk("r5_ack", 32'(rsv_ack), 32'h1);
    tick(); idle();
    rd_addr1 = 3'd5; #1;
    chk("r5_busy", 32'(rd_busy1), 32'h1);
    chk("r5_cnt1", 32'(busy_cnt), 32'h1);
    rsv_en = 1'b1; rsv_addr = 3'd5; #1;
    chk("r5_stall", 32'(rsv_ack), 32'h0);
    rsv_en = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h00A5;
    tick(); idle();
    #1;
    chk("r5_busy_clr", 32'(rd_busy1), 32'h0);
    chk("r5_cnt0", 32'(busy_cnt), 32'h0);
    chk("r5_data", 32'(rd_data1), 32'h00A5);

    // 4. busy r2, then write+reserve r2 in the same cycle
    rsv_en = 1'b1; rsv_addr = 3'd2;
    tick(); idle();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
    rsv_en = 1'b1; rsv_addr = 3'd2; #1;
    chk("r2_same_ack", 32'(rsv_ack), 32'h1);
    tick(); idle();
    rd_addr1 = 3'd2; #1;
    chk("r2_still_busy", 32'(rd_busy1), 32'h1);
    chk("r2_cnt", 32'(busy_cnt), 32'h1);
    chk("r2_data", 32'(rd_data1), 32'h2222);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
    tick(); idle();
    chk("r2_cnt_clr", 32'(busy_cnt), 32'h0);

    // 5. fill the scoreboard, r0 reserve, then drain
    for (int i = 1; i < 8; i++) begin
      rsv_en = 1'b1; rsv_addr = AW'(i); #1;
      chk($sformatf("fill_ack_r%0d", i), 32'(rsv_ack), 32'h1);
      tick();
    end
    idle();
    chk("fill_cnt7", 32'(busy_cnt), 32'h7);
    rsv_en = 1'b1; rsv_addr = 3'd0; #1;
    chk("r0_rsv_ack", 32'(rsv_ack), 32'h1);
    tick(); idle();
    chk("r0_rsv_cnt7", 32'(busy_cnt), 32'h7);
    for (int i = 1; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
      tick();
      chk($sformatf("drain_cnt_r%0d", i), 32'(busy_cnt), 32'(7 - i));
    end
    idle();

    // 6. same-cycle write/read of r4 (r4 holds 16'h0004 from the drain)
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0F0F;
    rd_addr1 = 3'd4; #1;
`ifdef GPR_BYPASS_EN
    chk("r4_same_cycle", 32'(rd_data1), 32'h0F0F);
`else
    chk("r4_same_cycle", 32'(rd_data1), 32'h0004);
`endif
    tick(); idle();
    chk("r4_next_cycle", 32'(rd_data1), 32'h0F0F);

    // busy visibility of a register being written this cycle
    rsv_en = 1'b1; rsv_addr = 3'd6;
    tick(); idle();
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
    rd_addr2 = 3'd6; #1;
`ifdef GPR_BYPASS_EN
    chk("r6_busy_fwd", 32'(rd_busy2), 32'h0);
`else
    chk("r6_busy_fwd", 32'(rd_busy2), 32'h1);
`endif
    tick(); idle();
    chk("r6_busy_after", 32'(rd_busy2), 32'h0);

    // asynchronous reset mid-cycle with state present
    rsv_en = 1'b1; rsv_addr = 3'd7;
    tick(); idle();
    rd_addr1 = 3'd4; rd_addr2 = 3'd7;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data1", 32'(rd_data1), 32'h0);
    chk("arst_busy2", 32'(rd_busy2), 32'h0);
    chk("arst_cnt", 32'(busy_cnt), 32'h0);
    rsv_en = 1'b1; rsv_addr = 3'd3; #1;
    chk("arst_ack", 32'(rsv_ack), 32'h0);
    rsv_en = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_r4", 32'(rd_data1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
